pipe_word_assembler: RTL and testbench
======================================

Name: pipe_word_assembler

Overview:
- Host-side initiator for the request PipeIn channel: assembles a stream of 32-bit link words into complete 16+128-bit pipe messages and enqueues them toward the pipe-to-method (P2M) converter in front of the DUT.
- Performs the reverse transform of the indication-side serializer.
- Provides header parsing, payload packing, overlength discard, output holding until the pipe accepts, and a message counter.

Parameters:
- TAG_WIDTH, 16, method tag field width; occupies the top bits of the pipe message.
- DATA_WIDTH, 128, payload width of the pipe message.
- WORD_WIDTH, 32, link word width. DATA_WIDTH must be a multiple of WORD_WIDTH.
- MAX_WORDS, DATA_WIDTH/WORD_WIDTH (4), derived. Maximum payload words per message.
- TIMEOUT_CYCLES, 1024, idle-cycle limit used only with the optional feature.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- nRST  in  1  reset: synchronous, active-low.
- word_valid  in  1  link word present.
- word_data  in  WORD_WIDTH  link word.
- word_rdy  out  1  assembler can accept a word this cycle.
- pipe_enq__ENA  out  1  message valid toward the request pipe.
- pipe_enq_v  out  TAG_WIDTH+DATA_WIDTH  message: {tag, payload}.
- pipe_enq__RDY  in  1  pipe accepts the message.
- msg_count  out  16  number of messages enqueued; wraps 0xFFFF->0.
- overlen_err  out  1  one-cycle pulse when an overlength header is seen.

Behaviour:
- Word transfer occurs when word_valid && word_rdy. Message transfer occurs when pipe_enq__ENA && pipe_enq__RDY.
- Header word layout: [31:16] tag; [15:0] N = payload word count.
- Reset (nRST=0 at a clock edge) produces: state IDLE, word_rdy=0 during reset then 1, pipe_enq__ENA=0, pipe_enq_v=0, msg_count=0, overlen_err=0, and the payload buffer cleared. Reset mid-message discards the partial message; no enqueue occurs.
- State IDLE:
  - word_rdy=1.
  - On a header word, latch the tag, clear the payload buffer and set idx=0.
  - N=0 -> SEND.
  - 1<=N<=MAX_WORDS -> COLLECT, with remaining=N.
  - N>MAX_WORDS -> pulse overlen_err next cycle, go to DRAIN with remaining=N.
- State COLLECT:
  - word_rdy=1.
  - Each accepted word is written to payload[idx*32 +: 32] (LSB-first), then idx++ and remaining--.
  - When the word with remaining==1 is accepted -> SEND.
  - Unfilled upper payload words are zero.
- State DRAIN:
  - word_rdy=1.
  - Accept and discard words until remaining reaches 0, then -> IDLE.
  - No message is produced and msg_count is unchanged.
- State SEND:
  - word_rdy=0.
  - pipe_enq__ENA=1 with pipe_enq_v={tag, payload}, held stable until pipe_enq__RDY.
  - On transfer: msg_count++ and -> IDLE in the same edge. ENA drops next cycle.
- Latency: last payload word accepted at edge t -> ENA high from cycle t+1. With pipe_enq__RDY tied high, one message is sent per N+2 cycles.
- Back-to-back: a new header is not accepted in the same cycle as the SEND transfer.
- overlen_err is registered, high exactly one cycle.
- word_valid deasserted mid-COLLECT: the assembler waits indefinitely unless the optional feature is enabled.

Optional Feature:
- Macro PIPE_ASM_TIMEOUT_EN.
- Defined:
  - An idle counter runs in COLLECT and DRAIN; it resets on every accepted word.
  - Reaching TIMEOUT_CYCLES aborts to IDLE, discards the partial message and pulses output timeout_err for one cycle.
  - The port timeout_err exists only under this macro.
- Undefined: no counter and no timeout_err port; the assembler waits forever.

Decomposition:
- Shared package pipe_asm_pkg holds:
  - the state enum (IDLE, COLLECT, DRAIN, SEND);
  - header field offsets;
  - the MAX_WORDS localparam formula;
  - the message struct {tag, payload}.
- Optional sub-module pipe_asm_watchdog (the timeout counter), instantiated only under PIPE_ASM_TIMEOUT_EN.
- Everything else lives in one module.

Test Plan:
- Header 0x0005_0002, then words 0x11111111, 0x22222222, RDY=1 -> one enqueue of tag 0x0005, payload 0x..._22222222_11111111 with upper 64 bits zero, one cycle after the last word; msg_count=1.
- Header 0x0007_0000 -> enqueue of tag 0x0007, payload 0, on the cycle after the header.
- Header 0x0003_0004, 4 words, RDY held 0 for 10 cycles -> ENA and v stay stable, word_rdy=0 throughout; RDY=1 -> transfer, then IDLE; msg_count increments once.
- Header 0x0009_0006, 6 words, then a valid N=1 message -> overlen_err pulses once, the 6 words are discarded, only the second message is enqueued.
- nRST=0 for one cycle after 2 of 4 payload words -> no enqueue; a following fresh message is assembled correctly; msg_count=0 then 1.
- With PIPE_ASM_TIMEOUT_EN and TIMEOUT_CYCLES=8: header N=3, one word, then 8 idle cycles -> timeout_err pulse, return to IDLE, no enqueue.

Source files
------------

// File: rtl/pipe_asm_pkg.sv
// Shared types and constants for the request-side pipe word assembler.
// Header layout: [31:16] method tag, [15:0] payload word count.
package pipe_asm_pkg;

    localparam int TAG_WIDTH     = 16;
    localparam int DATA_WIDTH    = 128;
    localparam int WORD_WIDTH    = 32;
    localparam int MAX_WORDS     = DATA_WIDTH / WORD_WIDTH;
    localparam int IDX_WIDTH     = $clog2(MAX_WORDS);

    localparam int HDR_TAG_LSB   = 16;
    localparam int HDR_LEN_LSB   = 0;
    localparam int HDR_LEN_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        SEND
    } state_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] payload;
    } msg_t;

endpackage

// File: rtl/pipe_asm_if.sv
// Link-word input and request-pipe output handshakes of the assembler.
// master = assembler side, slave = link source / pipe sink side.
interface pipe_asm_if;
    import pipe_asm_pkg::*;

    logic                            word_valid;
    logic [WORD_WIDTH-1:0]           word_data;
    logic                            word_rdy;
    logic                            pipe_enq__ENA;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] pipe_enq_v;
    logic                            pipe_enq__RDY;

    modport master (
        input  word_valid,
        input  word_data,
        output word_rdy,
        output pipe_enq__ENA,
        output pipe_enq_v,
        input  pipe_enq__RDY
    );

    modport slave (
        output word_valid,
        output word_data,
        input  word_rdy,
        input  pipe_enq__ENA,
        input  pipe_enq_v,
        output pipe_enq__RDY
    );

endinterface

// File: rtl/pipe_asm_watchdog.sv
// Idle-cycle counter: raises expired on the cycle whose edge would be the
// TIMEOUT_CYCLES-th consecutive idle edge while active.
module pipe_asm_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic nrst,
    input  logic active,
    input  logic kick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!nrst || !active || kick || expired) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expired = active && !kick && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pipe_word_assembler.sv
// Assembles 32-bit link words into {tag, payload} request-pipe messages.
// Optional idle timeout with timeout_err output: define PIPE_ASM_TIMEOUT_EN.
module pipe_word_assembler
    import pipe_asm_pkg::*;
`ifdef PIPE_ASM_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 1024
)
`endif
(
    input  logic        CLK,
    input  logic        nRST,
    pipe_asm_if.master  bus,
    output logic [15:0] msg_count,
`ifdef PIPE_ASM_TIMEOUT_EN
    output logic        timeout_err,
`endif
    output logic        overlen_err
);

    state_t                   state, state_next;
    msg_t                     msg;
    logic [IDX_WIDTH-1:0]     idx;
    logic [HDR_LEN_WIDTH-1:0] remaining;

    logic                     word_xfer;
    logic                     pipe_xfer;
    logic                     timeout_hit;
    logic [TAG_WIDTH-1:0]     hdr_tag;
    logic [HDR_LEN_WIDTH-1:0] hdr_len;

    assign word_xfer = bus.word_valid && bus.word_rdy;
    assign pipe_xfer = bus.pipe_enq__ENA && bus.pipe_enq__RDY;
    assign hdr_tag   = bus.word_data[HDR_TAG_LSB +: TAG_WIDTH];
    assign hdr_len   = bus.word_data[HDR_LEN_LSB +: HDR_LEN_WIDTH];

`ifdef PIPE_ASM_TIMEOUT_EN
    pipe_asm_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (CLK),
        .nrst   (nRST),
        .active (state == COLLECT || state == DRAIN),
        .kick   (word_xfer),
        .expired(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (word_xfer) begin
                    if (hdr_len == '0) begin
                        state_next = SEND;
                    end else if (hdr_len <= HDR_LEN_WIDTH'(MAX_WORDS)) begin
                        state_next = COLLECT;
                    end else begin
                        state_next = DRAIN;
                    end
                end
            end
            COLLECT: begin
                if (timeout_hit) begin
                    state_next = IDLE;
                end else if (word_xfer && remaining == HDR_LEN_WIDTH'(1)) begin
                    state_next = SEND;
                end
            end
            DRAIN: begin
                if (timeout_hit || (word_xfer && remaining == HDR_LEN_WIDTH'(1))) begin
                    state_next = IDLE;
                end
            end
            SEND: begin
                if (pipe_xfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The message bus reads as zero outside SEND so stale payloads never leak.
    always_comb begin
        bus.word_rdy      = nRST && (state != SEND);
        bus.pipe_enq__ENA = (state == SEND);
        bus.pipe_enq_v    = (state == SEND) ? msg : '0;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            msg         <= '0;
            idx         <= '0;
            remaining   <= '0;
            msg_count   <= '0;
            overlen_err <= 1'b0;
`ifdef PIPE_ASM_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            overlen_err <= 1'b0;
`ifdef PIPE_ASM_TIMEOUT_EN
            timeout_err <= timeout_hit;
`endif
            if (word_xfer) begin
                case (state)
                    IDLE: begin
                        msg.tag     <= hdr_tag;
                        msg.payload <= '0;
                        idx         <= '0;
                        remaining   <= hdr_len;
                        overlen_err <= (hdr_len > HDR_LEN_WIDTH'(MAX_WORDS));
                    end
                    COLLECT: begin
                        msg.payload[int'(idx)*WORD_WIDTH +: WORD_WIDTH] <= bus.word_data;
                        idx       <= idx + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                    DRAIN: begin
                        remaining <= remaining - 1'b1;
                    end
                    default: ;
                endcase
            end
            if (pipe_xfer) begin
                msg_count <= msg_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_word_assembler.sv
// Directed self-checking bench for pipe_word_assembler; inputs change and
// outputs are sampled on the falling clock edge.
module tb_pipe_word_assembler;

    logic        clk;
    logic        nrst;
    logic [15:0] msg_count;
    logic        overlen_err;
`ifdef PIPE_ASM_TIMEOUT_EN
    logic        timeout_err;
`endif

    int checks;
    int errors;
    logic [15:0]  exp_count;
    logic [143:0] exp_v;

    pipe_asm_if bus();

`ifdef PIPE_ASM_TIMEOUT_EN
    pipe_word_assembler #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK        (clk),
        .nRST       (nrst),
        .bus        (bus.master),
        .msg_count  (msg_count),
        .timeout_err(timeout_err),
        .overlen_err(overlen_err)
    );
`else
    pipe_word_assembler dut (
        .CLK        (clk),
        .nRST       (nrst),
        .bus        (bus.master),
        .msg_count  (msg_count),
        .overlen_err(overlen_err)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w);
        bus.word_valid = 1'b1;
        bus.word_data  = w;
        tick();
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_data = '0;
        bus.pipe_enq__RDY = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.word_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_word_rdy: got %b expected 0", bus.word_rdy);
        end
        checks++;
        if (bus.pipe_enq__ENA !== 1'b0 || bus.pipe_enq_v !== '0) begin
            errors++;
            $display("[TB] FAIL reset_enq: got ena=%b v=%h expected ena=0 v=0", bus.pipe_enq__ENA, bus.pipe_enq_v);
        end
        checks++;
        if (msg_count !== 16'd0 || overlen_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_count: got count=%h ovl=%b expected 0 0", msg_count, overlen_err);
        end
        nrst = 1'b1;
        #1;
        checks++;
        if (bus.word_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_word_rdy: got %b expected 1", bus.word_rdy);
        end
        exp_count = 16'd0;
        tick();
    endtask

    task automatic test_two_words();
        bus.pipe_enq__RDY = 1'b1;
        push(32'h0005_0002);
        push(32'h1111_1111);
        checks++;
        if (bus.pipe_enq__ENA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL two_early_ena: got %b expected 0", bus.pipe_enq__ENA);
        end
        push(32'h2222_2222);
        bus.word_valid = 1'b0;
        exp_v = {16'h0005, 64'h0, 32'h2222_2222, 32'h1111_1111};
        checks++;
        if (bus.pipe_enq__ENA !== 1'b1 || bus.pipe_enq_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL two_msg: got ena=%b v=%h expected ena=1 v=%h", bus.pipe_enq__ENA, bus.pipe_enq_v, exp_v);
        end
        checks++;
        if (bus.word_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL two_send_rdy: got %b expected 0", bus.word_rdy);
        end
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (bus.pipe_enq__ENA !== 1'b0 || msg_count !== exp_count) begin
            errors++;
            $display("[TB] FAIL two_after: got ena=%b count=%h expected ena=0 count=%h", bus.pipe_enq__ENA, msg_count, exp_count);
        end
    endtask

    task automatic test_zero_len();
        push(32'h0007_0000);
        bus.word_valid = 1'b0;
        exp_v = {16'h0007, 128'h0};
        checks++;
        if (bus.pipe_enq__ENA !== 1'b1 || bus.pipe_enq_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL zero_msg: got ena=%b v=%h expected ena=1 v=%h", bus.pipe_enq__ENA, bus.pipe_enq_v, exp_v);
        end
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (msg_count !== exp_count) begin
            errors++;
            $display("[TB] FAIL zero_count: got %h expected %h", msg_count, exp_count);
        end
    endtask

    task automatic test_hold();
        bus.pipe_enq__RDY = 1'b0;
        push(32'h0003_0004);
        push(32'hA000_0001);
        push(32'hA000_0002);
        push(32'hA000_0003);
        push(32'hA000_0004);
        bus.word_valid = 1'b0;
        exp_v = {16'h0003, 32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001};
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.pipe_enq__ENA !== 1'b1 || bus.pipe_enq_v !== exp_v || bus.word_rdy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_%0d: got ena=%b rdy=%b v=%h expected ena=1 rdy=0 v=%h", i, bus.pipe_enq__ENA, bus.word_rdy, bus.pipe_enq_v, exp_v);
            end
            checks++;
            if (msg_count !== exp_count) begin
                errors++;
                $display("[TB] FAIL hold_count_%0d: got %h expected %h", i, msg_count, exp_count);
            end
            tick();
        end
        bus.pipe_enq__RDY = 1'b1;
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (bus.pipe_enq__ENA !== 1'b0 || bus.word_rdy !== 1'b1 || msg_count !== exp_count) begin
            errors++;
            $display("[TB] FAIL hold_release: got ena=%b rdy=%b count=%h expected 0 1 %h", bus.pipe_enq__ENA, bus.word_rdy, msg_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        push(32'h0007_0000);
        bus.word_data = 32'h0008_0000;
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (bus.pipe_enq__ENA !== 1'b0 || bus.word_rdy !== 1'b1 || msg_count !== exp_count) begin
            errors++;
            $display("[TB] FAIL b2b_gap: got ena=%b rdy=%b count=%h expected 0 1 %h", bus.pipe_enq__ENA, bus.word_rdy, msg_count, exp_count);
        end
        tick();
        bus.word_valid = 1'b0;
        exp_v = {16'h0008, 128'h0};
        checks++;
        if (bus.pipe_enq__ENA !== 1'b1 || bus.pipe_enq_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL b2b_second: got ena=%b v=%h expected ena=1 v=%h", bus.pipe_enq__ENA, bus.pipe_enq_v, exp_v);
        end
        tick();
        exp_count = exp_count + 16'd1;
    endtask

    task automatic test_overlen();
        push(32'h0009_0006);
        checks++;
        if (overlen_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovl_pulse: got %b expected 1", overlen_err);
        end
        for (int i = 0; i < 6; i++) begin
            push(32'hBBBB_0000 + 32'(i));
            checks++;
            if (overlen_err !== 1'b0 || bus.pipe_enq__ENA !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ovl_drain_%0d: got ovl=%b ena=%b expected 0 0", i, overlen_err, bus.pipe_enq__ENA);
            end
        end
        push(32'h000A_0001);
        push(32'h1234_5678);
        bus.word_valid = 1'b0;
        exp_v = {16'h000A, 96'h0, 32'h1234_5678};
        checks++;
        if (bus.pipe_enq__ENA !== 1'b1 || bus.pipe_enq_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL ovl_next_msg: got ena=%b v=%h expected ena=1 v=%h", bus.pipe_enq__ENA, bus.pipe_enq_v, exp_v);
        end
        tick();
        exp_count = exp_count + 16'd1;
        checks++;
        if (msg_count !== exp_count) begin
            errors++;
            $display("[TB] FAIL ovl_count: got %h expected %h", msg_count, exp_count);
        end
    endtask

    task automatic test_reset_mid();
        push(32'h0003_0004);
        push(32'hC000_0001);
        push(32'hC000_0002);
        bus.word_valid = 1'b0;
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        exp_count = 16'd0;
        checks++;
        if (bus.pipe_enq__ENA !== 1'b0 || msg_count !== exp_count) begin
            errors++;
            $display("[TB] FAIL rst_mid: got ena=%b count=%h expected 0 0", bus.pipe_enq__ENA, msg_count);
        end
        push(32'h0004_0001);
        push(32'hCAFE_F00D);
        bus.word_valid = 1'b0;
        exp_v = {16'h0004, 96'h0, 32'hCAFE_F00D};
        checks++;
        if (bus.pipe_enq__ENA !== 1'b1 || bus.pipe_enq_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL rst_fresh_msg: got ena=%b v=%h expected ena=1 v=%h", bus.pipe_enq__ENA, bus.pipe_enq_v, exp_v);
        end
        tick();
        exp_count = 16'd1;
        checks++;
        if (msg_count !== exp_count) begin
            errors++;
            $display("[TB] FAIL rst_fresh_count: got %h expected %h", msg_count, exp_count);
        end
    endtask

`ifdef PIPE_ASM_TIMEOUT_EN
    task automatic test_timeout();
        push(32'h0006_0003);
        push(32'hD000_0001);
        bus.word_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (timeout_err !== 1'b0 || bus.word_rdy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL to_idle_%0d: got terr=%b rdy=%b expected 0 1", i, timeout_err, bus.word_rdy);
            end
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || bus.pipe_enq__ENA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_pulse: got terr=%b ena=%b expected 1 0", timeout_err, bus.pipe_enq__ENA);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0 || msg_count !== exp_count) begin
            errors++;
            $display("[TB] FAIL to_after: got terr=%b count=%h expected 0 %h", timeout_err, msg_count, exp_count);
        end
        push(32'h000B_0000);
        bus.word_valid = 1'b0;
        exp_v = {16'h000B, 128'h0};
        checks++;
        if (bus.pipe_enq__ENA !== 1'b1 || bus.pipe_enq_v !== exp_v) begin
            errors++;
            $display("[TB] FAIL to_next_msg: got ena=%b v=%h expected ena=1 v=%h", bus.pipe_enq__ENA, bus.pipe_enq_v, exp_v);
        end
        tick();
        exp_count = exp_count + 16'd1;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        exp_count = '0;
        exp_v = '0;
        nrst = 1'b0;
        bus.word_valid = 1'b0;
        bus.word_data = '0;
        bus.pipe_enq__RDY = 1'b0;
        test_reset();
        test_two_words();
        test_zero_len();
        test_hold();
        test_back_to_back();
        test_overlen();
        test_reset_mid();
`ifdef PIPE_ASM_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
